change_dispenser: RTL and testbench

- Consumes the 5-bit change amount and borrow flag produced by the change subtractor, then pays the change out as a sequence of physical coins.
- Uses a greedy largest-coin-first algorithm and tracks a per-denomination coin stock.
- Each coin is handed to the coin-ejector actuator over a valid/ready handshake.
- Sits between the arithmetic datapath and the ejector in the vending machine top level.

---
 rtl/change_dispenser.sv | 140 ++++++++++++++
 tb/tb_change_dispenser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy coin payout engine: turns a change amount into a stream of coin codes
// for the ejector, tracking a 4-bit stock counter per denomination.
module change_dispenser #(
  parameter int W          = 5,
  parameter int DEN3       = 10,
  parameter int DEN2       = 5,
  parameter int DEN1       = 2,
  parameter int STOCK_INIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] change_in,
  input  logic         borrow_in,
  input  logic         load_stock,
  input  logic [15:0]  stock_in,
  output logic         coin_valid,
  output logic [1:0]   coin_code,
  input  logic         coin_ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] remaining
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EMIT,
    ST_FINISH,
    ST_FAIL
  } state_t;

  localparam logic [3:0] L_STOCK_INIT = 4'(STOCK_INIT);

  state_t       r_state, w_state_next;
  logic [W-1:0] r_remaining, w_remaining_next;
  logic         r_coin_valid, w_coin_valid_next;
  logic [1:0]   r_coin_code, w_coin_code_next;
  logic [3:0]   r_stock [4];
  logic [3:0]   w_stock_next [4];

  logic [W-1:0] w_den [4];
  logic [3:0]   w_eligible;
  logic         w_sel_found;
  logic [1:0]   w_sel_code;

  assign w_den[0] = W'(1);
  assign w_den[1] = W'(DEN1);
  assign w_den[2] = W'(DEN2);
  assign w_den[3] = W'(DEN3);

  // A coin qualifies only if it fits in what is owed and is in stock, which
  // also guarantees the subtraction and stock decrement never wrap.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_elig
      assign w_eligible[gi] = (w_den[gi] <= r_remaining) && (r_stock[gi] != 4'd0);
    end
  endgenerate

  always_comb begin
    w_sel_found = |w_eligible;
    if (w_eligible[3])      w_sel_code = 2'd3;
    else if (w_eligible[2]) w_sel_code = 2'd2;
    else if (w_eligible[1]) w_sel_code = 2'd1;
    else                    w_sel_code = 2'd0;
  end

  always_comb begin
    w_state_next      = r_state;
    w_remaining_next  = r_remaining;
    w_coin_valid_next = r_coin_valid;
    w_coin_code_next  = r_coin_code;
    for (int i = 0; i < 4; i++) w_stock_next[i] = r_stock[i];

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_remaining_next = change_in;
          w_state_next     = borrow_in ? ST_FAIL : ST_SELECT;
        end else if (load_stock) begin
          for (int i = 0; i < 4; i++) w_stock_next[i] = stock_in[4*i +: 4];
        end
      end
      ST_SELECT: begin
        if (r_remaining == '0) begin
          w_state_next = ST_FINISH;
        end else if (w_sel_found) begin
          w_coin_code_next  = w_sel_code;
          w_coin_valid_next = 1'b1;
          w_state_next      = ST_EMIT;
        end else begin
          w_state_next = ST_FAIL;
        end
      end
      ST_EMIT: begin
        if (coin_ready) begin
          w_remaining_next              = r_remaining - w_den[r_coin_code];
          w_stock_next[r_coin_code]     = r_stock[r_coin_code] - 4'd1;
          w_coin_valid_next             = 1'b0;
          w_state_next                  = ST_SELECT;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      ST_FAIL:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_coin_valid <= 1'b0;
      r_coin_code  <= 2'd0;
    end else begin
      r_state      <= w_state_next;
      r_remaining  <= w_remaining_next;
      r_coin_valid <= w_coin_valid_next;
      r_coin_code  <= w_coin_code_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stock
      always_ff @(posedge clk) begin
        if (rst) r_stock[gi] <= L_STOCK_INIT;
        else     r_stock[gi] <= w_stock_next[gi];
      end
    end
  endgenerate

  assign coin_valid = r_coin_valid;
  assign coin_code  = r_coin_code;
  assign remaining  = r_remaining;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_FINISH) || (r_state == ST_FAIL);
  assign err        = (r_state == ST_FAIL);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payouts, stock fallback,
// failure paths, backpressure and reset during a payout.
module tb_change_dispenser;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  change_in;
  logic        borrow_in;
  logic        load_stock;
  logic [15:0] stock_in;
  logic        coin_valid;
  logic [1:0]  coin_code;
  logic        coin_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  remaining;

  change_dispenser #(
    .W(5), .DEN3(10), .DEN2(5), .DEN1(2), .STOCK_INIT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .change_in(change_in),
    .borrow_in(borrow_in), .load_stock(load_stock), .stock_in(stock_in),
    .coin_valid(coin_valid), .coin_code(coin_code), .coin_ready(coin_ready),
    .busy(busy), .done(done), .err(err), .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] got_codes[$];
  logic       got_done;
  logic       got_err;
  logic [4:0] got_rem;
  int         got_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    load_stock = 1'b1;
    stock_in   = v;
    tick();
    load_stock = 1'b0;
  endtask

  task automatic check_stocks(input string tag, input logic [15:0] exp);
    check({tag, "_s0"}, 32'(dut.r_stock[0]), 32'(exp[3:0]));
    check({tag, "_s1"}, 32'(dut.r_stock[1]), 32'(exp[7:4]));
    check({tag, "_s2"}, 32'(dut.r_stock[2]), 32'(exp[11:8]));
    check({tag, "_s3"}, 32'(dut.r_stock[3]), 32'(exp[15:12]));
  endtask

  // Runs one payout with the current coin_ready; got_cyc counts cycles after the start edge.
  task automatic payout(input string tag, input logic [4:0] amt, input logic brw);
    got_codes.delete();
    got_done = 1'b0;
    got_err  = 1'b0;
    got_rem  = '0;
    got_cyc  = 0;
    change_in = amt;
    borrow_in = brw;
    start     = 1'b1;
    tick();
    start      = 1'b0;
    load_stock = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int c = 1; c <= 200; c++) begin
      if (coin_valid && coin_ready) got_codes.push_back(coin_code);
      if (done) begin
        got_done = 1'b1;
        got_err  = err;
        got_rem  = remaining;
        got_cyc  = c;
        break;
      end
      tick();
    end
    check({tag, "_done_seen"}, 32'(got_done), 32'd1);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_coins(input string tag, input int n, input logic [15:0] codes);
    check({tag, "_ncoins"}, 32'(got_codes.size()), 32'(n));
    for (int i = 0; i < n && i < got_codes.size(); i++)
      check($sformatf("%s_coin%0d", tag, i), 32'(got_codes[i]), 32'(codes[2*i +: 2]));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    change_in  = '0;
    borrow_in  = 1'b0;
    load_stock = 1'b0;
    stock_in   = '0;
    coin_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_valid", 32'(coin_valid), 32'd0);
    check("rst_code", 32'(coin_code), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rem", 32'(remaining), 32'd0);
    check_stocks("rst", 16'h8888);

    // 18 = 10 + 5 + 2 + 1
    payout("basic", 5'd18, 1'b0);
    check_coins("basic", 4, 16'h001B);
    check("basic_err", 32'(got_err), 32'd0);
    check("basic_rem", 32'(got_rem), 32'd0);
    check("basic_cyc", 32'(got_cyc), 32'd10);
    check_stocks("basic", 16'h7777);

    // Zero change, with a simultaneous load that start must override
    load_stock = 1'b1;
    stock_in   = 16'h0000;
    payout("zero", 5'd0, 1'b0);
    check_coins("zero", 0, 16'h0000);
    check("zero_err", 32'(got_err), 32'd0);
    check("zero_cyc", 32'(got_cyc), 32'd2);
    check_stocks("zero", 16'h7777);

    payout("borrow", 5'd5, 1'b1);
    check_coins("borrow", 0, 16'h0000);
    check("borrow_err", 32'(got_err), 32'd1);
    check("borrow_rem", 32'(got_rem), 32'd5);
    check("borrow_cyc", 32'(got_cyc), 32'd1);

    // No tens: 20 must come out as four fives
    load(16'h0888);
    payout("fallback", 5'd20, 1'b0);
    check_coins("fallback", 4, 16'h00AA);
    check("fallback_err", 32'(got_err), 32'd0);
    check("fallback_rem", 32'(got_rem), 32'd0);
    check_stocks("fallback", 16'h0488);

    load(16'h0000);
    payout("empty", 5'd3, 1'b0);
    check_coins("empty", 0, 16'h0000);
    check("empty_err", 32'(got_err), 32'd1);
    check("empty_rem", 32'(got_rem), 32'd3);
    check("empty_cyc", 32'(got_cyc), 32'd2);

    load(16'h0100);
    payout("partial", 5'd7, 1'b0);
    check_coins("partial", 1, 16'h0002);
    check("partial_err", 32'(got_err), 32'd1);
    check("partial_rem", 32'(got_rem), 32'd2);
    check("partial_cyc", 32'(got_cyc), 32'd4);
    check_stocks("partial", 16'h0000);

    // Backpressure on the first coin, plus start/load attempts while busy
    load(16'h8888);
    coin_ready = 1'b0;
    change_in  = 5'd10;
    borrow_in  = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("bp_c1_valid", 32'(coin_valid), 32'd0);
    tick();
    start      = 1'b1;
    change_in  = 5'd3;
    load_stock = 1'b1;
    stock_in   = 16'h0000;
    for (int c = 2; c <= 4; c++) begin
      check($sformatf("bp_c%0d_valid", c), 32'(coin_valid), 32'd1);
      check($sformatf("bp_c%0d_code", c), 32'(coin_code), 32'd3);
      check($sformatf("bp_c%0d_rem", c), 32'(remaining), 32'd10);
      check($sformatf("bp_c%0d_done", c), 32'(done), 32'd0);
      tick();
      start      = 1'b0;
      load_stock = 1'b0;
    end
    coin_ready = 1'b1;
    got_done = 1'b0;
    got_cyc  = 0;
    for (int c = 5; c <= 100; c++) begin
      if (done) begin
        got_done = 1'b1;
        got_err  = err;
        got_rem  = remaining;
        got_cyc  = c;
        break;
      end
      tick();
    end
    check("bp_done_seen", 32'(got_done), 32'd1);
    check("bp_cyc", 32'(got_cyc), 32'd7);
    check("bp_err", 32'(got_err), 32'd0);
    check("bp_rem", 32'(got_rem), 32'd0);
    check_stocks("bp", 16'h7888);
    tick();
    check("bp_idle", 32'(busy), 32'd0);

    // Reset while a coin is being offered
    coin_ready = 1'b0;
    change_in  = 5'd10;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_valid_before", 32'(coin_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_valid", 32'(coin_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_rem", 32'(remaining), 32'd0);
    check_stocks("mid", 16'h8888);
    tick();
    check("mid_done_after", 32'(done), 32'd0);
    check("mid_busy_after", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
